// File: rtl/filter_buf_pp.sv
// ---------------------------------------------------------------------------
// filter_buf_pp
// Double-buffered (ping-pong) K x K filter coefficient buffer. The weight
// fetch path loads one filter row per accepted handshake into the write bank.
// Meanwhile the PE array reads the complete filter held in the other bank.
//
// Parameters:
//   DW  coefficient width in bits
//   K   filter dimension (K x K coefficients), 2..8
//
// Ports:
//   clk         clock, all state on rising edge
//   rst_n       asynchronous active-low reset
//   flush       synchronous clear of bank/pointer state
//   wr_valid    row write request
//   wr_ready    write bank is free and accepting rows
//   wr_row      one filter row, column c in bits [c*DW +: DW]
//   rd_valid    a complete filter is presented on data_out
//   rd_done     consumer releases the presented filter
//   data_out    flattened filter, row 0 col 0 in the MSBs (row-major)
//   fill_level  number of full banks (0..2)
//   flip        (only with FILTER_BUF_PP_FLIP_EN) present filter rotated 180 deg
//
// Optional feature macro: FILTER_BUF_PP_FLIP_EN
// ---------------------------------------------------------------------------
module filter_buf_pp #(
  parameter int DW = 8,
  parameter int K  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [K*DW-1:0]   wr_row,
  output logic              rd_valid,
  input  logic              rd_done,
`ifdef FILTER_BUF_PP_FLIP_EN
  input  logic              flip,
`endif
  output logic [K*K*DW-1:0] data_out,
  output logic [1:0]        fill_level
);

  localparam int RW = $clog2(K);

  logic [DW-1:0] mem [2][K][K];
  logic          wr_bank;
  logic          rd_bank;
  logic [1:0]    full;
  logic [RW-1:0] row_cnt;

  logic wr_fire;
  logic rd_fire;

  assign wr_ready   = ~full[wr_bank];
  assign rd_valid   = full[rd_bank];
  assign fill_level = {1'b0, full[0]} + {1'b0, full[1]};

  // flush discards a write or release presented in the same cycle
  assign wr_fire = wr_valid & wr_ready & ~flush;
  assign rd_fire = rd_done & rd_valid & ~flush;

  // Coefficient storage has no reset; stale contents are masked by full[].
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int c = 0; c < K; c++) begin
        mem[wr_bank][row_cnt][c] <= wr_row[c*DW +: DW];
      end
    end
  end

  // Bank pointers and full flags. A completion and a release in the same
  // cycle always touch different banks: the write bank must be empty to
  // accept, and the read bank must be full to release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full    <= 2'b00;
      row_cnt <= '0;
    end else if (flush) begin
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full    <= 2'b00;
      row_cnt <= '0;
    end else begin
      if (wr_fire) begin
        if (row_cnt == RW'(K-1)) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
          row_cnt       <= '0;
        end else begin
          row_cnt <= row_cnt + RW'(1);
        end
      end
      if (rd_fire) begin
        full[rd_bank] <= 1'b0;
        rd_bank       <= ~rd_bank;
      end
    end
  end

  // Element (r,c) lands at flat index r*K+c counted from the MSB end.
  always_comb begin
    data_out = '0;
    if (rd_valid) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K; c++) begin
`ifdef FILTER_BUF_PP_FLIP_EN
          if (flip) begin
            data_out[(K*K-1-(r*K+c))*DW +: DW] = mem[rd_bank][K-1-r][K-1-c];
          end else begin
            data_out[(K*K-1-(r*K+c))*DW +: DW] = mem[rd_bank][r][c];
          end
`else
          data_out[(K*K-1-(r*K+c))*DW +: DW] = mem[rd_bank][r][c];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_filter_buf_pp.sv
// ---------------------------------------------------------------------------
// tb_filter_buf_pp
// Testbench for filter_buf_pp (DW=8, K=4). Stimulus pushes each completed
// filter into an expected queue. A negedge monitor compares the presented
// filter and the flag outputs against the queue head, and pops the head when
// a release is issued. Directed checks against hand-computed constants cover
// the individual scenarios.
// Ports: none (self-contained). Honours FILTER_BUF_PP_FLIP_EN for the flip port.
// ---------------------------------------------------------------------------
module tb_filter_buf_pp;

  localparam int DW = 8;
  localparam int K  = 4;
  localparam int FW = K*K*DW;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic          wr_valid;
  logic          wr_ready;
  logic [K*DW-1:0] wr_row;
  logic          rd_valid;
  logic          rd_done;
  logic [FW-1:0] data_out;
  logic [1:0]    fill_level;
`ifdef FILTER_BUF_PP_FLIP_EN
  logic          flip;
`endif

  int tests_run;
  int tests_failed;

  logic [FW-1:0]   exp_q[$];
  logic [K*DW-1:0] rows_m[K];
  int              row_m;
  logic            acc;

  filter_buf_pp #(.DW(DW), .K(K)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_row     (wr_row),
    .rd_valid   (rd_valid),
    .rd_done    (rd_done),
`ifdef FILTER_BUF_PP_FLIP_EN
    .flip       (flip),
`endif
    .data_out   (data_out),
    .fill_level (fill_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [FW-1:0] actual,
                             input logic [FW-1:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Reference assembly of a stored filter into the row-major output word.
  function automatic logic [FW-1:0] buildFilter();
    logic [FW-1:0] f;
    f = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        f[(K*K-1-(r*K+c))*DW +: DW] = rows_m[r][c*DW +: DW];
    return f;
  endfunction

  // A 180-degree rotation reverses the order of the flattened elements.
  function automatic logic [FW-1:0] rotateFilter(input logic [FW-1:0] f);
    logic [FW-1:0] o;
    for (int i = 0; i < K*K; i++)
      o[i*DW +: DW] = f[(K*K-1-i)*DW +: DW];
    return o;
  endfunction

  // Drives one cycle of inputs (called at posedge+1) and updates the model
  // at the following edge. Acceptance is decided from the model before the edge.
  task automatic applyStimulus(input logic v, input logic [K*DW-1:0] row,
                               input logic done, input logic fl,
                               output logic accepted);
    wr_valid = v;
    wr_row   = row;
    rd_done  = done;
    flush    = fl;
    accepted = v && !fl && (exp_q.size() < 2);
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
      row_m = 0;
    end else if (accepted) begin
      rows_m[row_m] = row;
      if (row_m == K-1) begin
        exp_q.push_back(buildFilter());
        row_m = 0;
      end else begin
        row_m++;
      end
    end
    #1;
  endtask

  task automatic loadFilter(input logic [7:0] base, input logic done);
    logic a;
    for (int r = 0; r < K; r++) begin
      applyStimulus(1'b1, {base + 8'(4*r+3), base + 8'(4*r+2),
                           base + 8'(4*r+1), base + 8'(4*r)}, done, 1'b0, a);
      checkOutput("load_accept", FW'(a), FW'(1));
    end
  endtask

  task automatic checkFlags(input string name, input logic rv,
                            input logic [1:0] fl, input logic wr);
    checkOutput({name, "_rd_valid"},   FW'(rd_valid),   FW'(rv));
    checkOutput({name, "_fill_level"}, FW'(fill_level), FW'(fl));
    checkOutput({name, "_wr_ready"},   FW'(wr_ready),   FW'(wr));
  endtask

  // Monitor: compares outputs against the queue head every cycle and retires
  // the head when a release will be taken at the next edge.
  always @(negedge clk) begin
    logic [FW-1:0] exp_d;
    logic          exp_v;
    if (rst_n) begin
      exp_v = (exp_q.size() > 0);
      checkOutput("mon_rd_valid", FW'(rd_valid), FW'(exp_v));
      checkOutput("mon_fill_level", FW'(fill_level), FW'(exp_q.size()));
      checkOutput("mon_wr_ready", FW'(wr_ready), FW'(exp_q.size() < 2));
      exp_d = '0;
      if (exp_v) begin
        exp_d = exp_q[0];
`ifdef FILTER_BUF_PP_FLIP_EN
        if (flip) exp_d = rotateFilter(exp_q[0]);
`endif
      end
      checkOutput("mon_data_out", data_out, exp_d);
      if (rd_done && exp_v && !flush) exp_q.pop_front();
    end
  end

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    row_m        = 0;
    rst_n        = 1'b0;
    flush        = 1'b0;
    wr_valid     = 1'b0;
    wr_row       = '0;
    rd_done      = 1'b0;
`ifdef FILTER_BUF_PP_FLIP_EN
    flip         = 1'b0;
`endif

    // reset state
    #12;
    checkFlags("reset", 1'b0, 2'd0, 1'b1);
    checkOutput("reset_data_out", data_out, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // single load; rd_valid only after the last row's edge
    loadFilter(8'h00, 1'b0);
    checkFlags("single", 1'b1, 2'd1, 1'b1);
    checkOutput("single_data_out", data_out, 128'h000102030405060708090A0B0C0D0E0F);

    // second filter fills the other bank; a further row is held off
    loadFilter(8'h10, 1'b0);
    checkFlags("both_full", 1'b1, 2'd2, 1'b0);
    checkOutput("both_full_data_out", data_out, 128'h000102030405060708090A0B0C0D0E0F);
    applyStimulus(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, acc);
    checkOutput("held_row_accept", FW'(acc), FW'(0));
    checkFlags("held_row", 1'b1, 2'd2, 1'b0);
    checkOutput("held_row_data_out", data_out, 128'h000102030405060708090A0B0C0D0E0F);

    // release A; B becomes visible
    applyStimulus(1'b0, '0, 1'b1, 1'b0, acc);
    checkFlags("swap", 1'b1, 2'd1, 1'b1);
    checkOutput("swap_data_out", data_out, 128'h101112131415161718191A1B1C1D1E1F);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, acc);
    checkFlags("drain", 1'b0, 2'd0, 1'b1);

    // simultaneous release with a stalled row
    loadFilter(8'h20, 1'b0);
    loadFilter(8'h30, 1'b0);
    applyStimulus(1'b1, 32'h43424140, 1'b1, 1'b0, acc);
    checkOutput("stall_release_accept", FW'(acc), FW'(0));
    checkFlags("stall_release", 1'b1, 2'd1, 1'b1);
    checkOutput("stall_release_data_out", data_out, 128'h303132333435363738393A3B3C3D3E3F);
    loadFilter(8'h40, 1'b0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, acc);
    checkOutput("freed_bank_data_out", data_out, 128'h404142434445464748494A4B4C4D4E4F);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, acc);
    checkFlags("drain2", 1'b0, 2'd0, 1'b1);

    // flush mid-load, then a clean load
    applyStimulus(1'b1, 32'hA3A2A1A0, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 32'hA7A6A5A4, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 32'hABAAA9A8, 1'b0, 1'b1, acc);
    checkFlags("flush", 1'b0, 2'd0, 1'b1);
    checkOutput("flush_data_out", data_out, '0);
    loadFilter(8'h50, 1'b0);
    checkFlags("after_flush", 1'b1, 2'd1, 1'b1);
    checkOutput("after_flush_data_out", data_out, 128'h505152535455565758595A5B5C5D5E5F);
    applyStimulus(1'b0, '0, 1'b1, 1'b1, acc);
    checkFlags("flush_over_release", 1'b0, 2'd0, 1'b1);

    // async reset mid-load
    applyStimulus(1'b1, 32'hB3B2B1B0, 1'b0, 1'b0, acc);
    applyStimulus(1'b1, 32'hB7B6B5B4, 1'b0, 1'b0, acc);
    wr_valid = 1'b0;
    #2 rst_n = 1'b0;
    exp_q.delete();
    row_m = 0;
    #1;
    checkFlags("mid_reset", 1'b0, 2'd0, 1'b1);
    checkOutput("mid_reset_data_out", data_out, '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    loadFilter(8'h60, 1'b0);
    checkOutput("after_reset_data_out", data_out, 128'h606162636465666768696A6B6C6D6E6F);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, acc);

    // sustained throughput with rd_done held high
    for (int f = 0; f < 3; f++) loadFilter(8'h70 + 8'(16*f), 1'b1);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, acc);
    checkFlags("stream_end", 1'b0, 2'd0, 1'b1);

`ifdef FILTER_BUF_PP_FLIP_EN
    flip = 1'b1;
    loadFilter(8'h00, 1'b0);
    checkOutput("flip_data_out", data_out, 128'h0F0E0D0C0B0A09080706050403020100);
    flip = 1'b0;
    #1;
    checkOutput("noflip_data_out", data_out, 128'h000102030405060708090A0B0C0D0E0F);
    applyStimulus(1'b0, '0, 1'b1, 1'b0, acc);
`endif

    applyStimulus(1'b0, '0, 1'b0, 1'b0, acc);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, acc);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
